fp8_normalizador: RTL and testbench



---
 rtl/fp8_normalizador.sv | 176 +++++++++++++++++
 tb/tb_fp8_normalizador.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp8_normalizador.sv
// fp8_normalizador
// Normalise / round-to-nearest-even / saturate / pack stage of the 8-bit
// floating-point multiplier (1 sign, 4-bit exponent with bias 7, 3-bit
// mantissa with hidden 1). Two-stage elastic pipeline with valid/ready on
// both sides.
//
// Ports:
//   i_clk        clock, all state changes on rising edge
//   i_rst_n      synchronous active-low reset
//   i_valid      upstream presents an operand set
//   o_ready      operand set accepted this cycle (when i_valid is high)
//   i_producto   unsigned significand product, 64..225
//   i_exponente  signed exponent sum already corrected for bias, -7..23
//   i_signo      sign of the result
//   i_cero       one operand is zero; forces a signed zero result
//   o_valid      o_resultado and flags are valid
//   i_ready      downstream accepts the output
//   o_resultado  {sign, exp[3:0], mant[2:0]}
//   o_overflow   result saturated high (qualified by o_valid)
//   o_underflow  result flushed to zero (qualified by o_valid)
module fp8_normalizador (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [7:0] i_producto,
    input  logic [5:0] i_exponente,
    input  logic       i_signo,
    input  logic       i_cero,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_resultado,
    output logic       o_overflow,
    output logic       o_underflow
);

    // Stage 1 holding register (normalised, not yet rounded)
    logic              s1_valid_r;
    logic [2:0]        s1_mant_r;
    logic              s1_g_r;
    logic              s1_s_r;
    logic signed [6:0] s1_exp_r;
    logic              s1_sign_r;
    logic              s1_cero_r;

    // Stage 2 holding register (final packed word)
    logic              s2_valid_r;
    logic [7:0]        s2_res_r;
    logic              s2_ov_r;
    logic              s2_un_r;

    // Handshake control
    logic              s2_free_s;
    logic              s1_free_s;
    logic              s1_load_s;
    logic              s2_load_s;

    // Normalise datapath
    logic [2:0]        n_mant_s;
    logic              n_g_s;
    logic              n_s_s;
    logic signed [6:0] n_exp_s;

    // Round / saturate datapath
    logic              rnd_s;
    logic [3:0]        mant_sum_s;
    logic signed [6:0] exp_f_s;
    logic [7:0]        res_s;
    logic              ov_s;
    logic              un_s;

    // A stage may load when empty or when the stage ahead of it frees now.
    // o_ready depends on i_ready and the stage valid bits only.
    assign s2_free_s = !s2_valid_r || i_ready;
    assign s1_free_s = !s1_valid_r || s2_free_s;
    assign s1_load_s = i_valid && s1_free_s;
    assign s2_load_s = s1_valid_r && s2_free_s;
    assign o_ready   = s1_free_s;

    // Normalise: pick mantissa, guard and sticky depending on product MSB
    always_comb begin
        n_mant_s = 3'b000;
        n_g_s    = 1'b0;
        n_s_s    = 1'b0;
        n_exp_s  = {i_exponente[5], i_exponente};
        if (i_producto[7]) begin
            n_mant_s = i_producto[6:4];
            n_g_s    = i_producto[3];
            n_s_s    = |i_producto[2:0];
            n_exp_s  = {i_exponente[5], i_exponente} + 7'sd1;
        end else begin
            n_mant_s = i_producto[5:3];
            n_g_s    = i_producto[2];
            n_s_s    = |i_producto[1:0];
            n_exp_s  = {i_exponente[5], i_exponente};
        end
    end

    // Round to nearest even, fold mantissa carry into exponent, saturate, pack
    always_comb begin
        rnd_s      = s1_g_r && (s1_s_r || s1_mant_r[0]);
        mant_sum_s = {1'b0, s1_mant_r} + {3'b000, rnd_s};
        // mant_sum_s[3] is the 111+1 carry; the low three bits are then 000
        exp_f_s    = s1_exp_r + $signed({6'b000000, mant_sum_s[3]});
        res_s      = 8'h00;
        ov_s       = 1'b0;
        un_s       = 1'b0;
        if (s1_cero_r) begin
            res_s = {s1_sign_r, 7'b0000000};
            ov_s  = 1'b0;
            un_s  = 1'b0;
        end else if (exp_f_s >= 7'sd15) begin
            res_s = {s1_sign_r, 4'hF, 3'b000};
            ov_s  = 1'b1;
            un_s  = 1'b0;
        end else if (exp_f_s <= 7'sd0) begin
            res_s = {s1_sign_r, 7'b0000000};
            ov_s  = 1'b0;
            un_s  = 1'b1;
        end else begin
            res_s = {s1_sign_r, exp_f_s[3:0], mant_sum_s[2:0]};
            ov_s  = 1'b0;
            un_s  = 1'b0;
        end
    end

    // Stage 1 register: valid bit follows the input when the stage can load
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_mant_r  <= 3'b000;
            s1_g_r     <= 1'b0;
            s1_s_r     <= 1'b0;
            s1_exp_r   <= 7'sd0;
            s1_sign_r  <= 1'b0;
            s1_cero_r  <= 1'b0;
        end else begin
            if (s1_free_s) begin
                s1_valid_r <= i_valid;
            end
            if (s1_load_s) begin
                s1_mant_r <= n_mant_s;
                s1_g_r    <= n_g_s;
                s1_s_r    <= n_s_s;
                s1_exp_r  <= n_exp_s;
                s1_sign_r <= i_signo;
                s1_cero_r <= i_cero;
            end
        end
    end

    // Stage 2 register: output word and flags hold while stalled
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid_r <= 1'b0;
            s2_res_r   <= 8'h00;
            s2_ov_r    <= 1'b0;
            s2_un_r    <= 1'b0;
        end else begin
            if (s2_free_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (s2_load_s) begin
                s2_res_r <= res_s;
                s2_ov_r  <= ov_s;
                s2_un_r  <= un_s;
            end
        end
    end

    assign o_valid     = s2_valid_r;
    assign o_resultado = s2_res_r;
    assign o_overflow  = s2_ov_r;
    assign o_underflow = s2_un_r;

endmodule

// File: tb/tb_fp8_normalizador.sv
// Directed testbench for fp8_normalizador: reset state, latency, rounding,
// saturation/zero handling, streaming throughput, backpressure and mid-flight
// reset. Inputs change 1 time unit after the rising edge.
module tb_fp8_normalizador;

    logic       clk;
    logic       rst_n;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] producto;
    logic [5:0] exponente;
    logic       signo;
    logic       cero;
    logic       dn_valid;
    logic       dn_ready;
    logic [7:0] resultado;
    logic       overflow;
    logic       underflow;

    int checks;
    int errors;

    fp8_normalizador dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (up_valid),
        .o_ready     (up_ready),
        .i_producto  (producto),
        .i_exponente (exponente),
        .i_signo     (signo),
        .i_cero      (cero),
        .o_valid     (dn_valid),
        .i_ready     (dn_ready),
        .o_resultado (resultado),
        .o_overflow  (overflow),
        .o_underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand, leave it accepted at the next edge and return
    // 1 time unit after the second edge following acceptance.
    task automatic send_op(input logic [7:0] p, input logic [5:0] e,
                           input logic s, input logic c);
        producto  = p;
        exponente = e;
        signo     = s;
        cero      = c;
        up_valid  = 1'b1;
        @(posedge clk); #1;
        up_valid  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        up_valid = 1'b0;
        dn_ready = 1'b0;
        producto = 8'h00; exponente = 6'd0; signo = 1'b0; cero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dn_valid); end
        checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL reset_res got %h want 00", resultado); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {overflow, underflow}); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", up_ready); end
        dn_ready = 1'b1;
    endtask

    // 1.0 x 1.0 with explicit 2-cycle latency check
    task automatic test_basic();
        producto = 8'h40; exponente = 6'd7; signo = 1'b0; cero = 1'b0;
        up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", dn_valid); end
        @(posedge clk); #1;
        checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", dn_valid); end
        checks++; if (resultado !== 8'h38) begin errors++; $display("FAIL basic_res got %h want 38", resultado); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {overflow, underflow}); end
        @(posedge clk); #1;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", dn_valid); end
    endtask

    // Ties to even, round up on odd tie, mantissa carry, P[7] path
    task automatic test_rounding();
        logic [7:0] tp [4] = '{8'd100, 8'd108, 8'd126, 8'd144};
        logic [7:0] tr [4] = '{8'h3C, 8'h3E, 8'h40, 8'h41};
        for (int i = 0; i < 4; i++) begin
            send_op(tp[i], 6'd7, 1'b0, 1'b0);
            checks++; if (dn_valid !== 1'b1 || resultado !== tr[i]) begin
                errors++; $display("FAIL round_%0d got v=%b %h want v=1 %h", i, dn_valid, resultado, tr[i]);
            end
            checks++; if ({overflow, underflow} !== 2'b00) begin
                errors++; $display("FAIL round_flags_%0d got %b want 00", i, {overflow, underflow});
            end
        end
    endtask

    // Saturation, flush to zero, extremes of the normal range, zero operand
    task automatic test_saturation();
        logic [7:0] tp [8] = '{8'd144, 8'd127, 8'd225, 8'd64, 8'd64, 8'd64, 8'd144, 8'd144};
        logic [5:0] te [8] = '{6'd14, 6'd14, 6'd13, 6'd0, 6'b111001, 6'd1, 6'd7, 6'd14};
        logic       ts [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] tr [8] = '{8'hF8, 8'h78, 8'h76, 8'h00, 8'h80, 8'h08, 8'h80, 8'h80};
        logic [1:0] tf [8] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 8; i++) begin
            send_op(tp[i], te[i], ts[i], tc[i]);
            checks++; if (dn_valid !== 1'b1 || resultado !== tr[i]) begin
                errors++; $display("FAIL sat_%0d got v=%b %h want v=1 %h", i, dn_valid, resultado, tr[i]);
            end
            checks++; if ({overflow, underflow} !== tf[i]) begin
                errors++; $display("FAIL sat_flags_%0d got %b want %b", i, {overflow, underflow}, tf[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    // Stream five operands; mode 0 keeps i_ready high, mode 1 toggles it
    // 1,0,0,1,... A queue tracks accepted-but-undelivered results.
    task automatic test_stream(input int mode);
        logic [7:0] tp [5] = '{8'd64, 8'd100, 8'd108, 8'd126, 8'd144};
        logic [7:0] tr [5] = '{8'h38, 8'h3C, 8'h3E, 8'h40, 8'h41};
        logic [7:0] q [$];
        int  idx = 0;
        int  drained = 0;
        int  cyc = 0;
        bit  saw_stall = 1'b0;
        bit  acc;
        bit  drn;
        logic exp_ready;
        while (drained < 5 && cyc < 40) begin
            dn_ready  = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            up_valid  = (idx < 5);
            producto  = tp[(idx < 5) ? idx : 4];
            exponente = 6'd7;
            signo     = 1'b0;
            cero      = 1'b0;
            @(negedge clk);
            exp_ready = (q.size() < 2) || dn_ready;
            checks++; if (up_ready !== exp_ready) begin
                errors++; $display("FAIL stream%0d_ready c%0d got %b want %b", mode, cyc, up_ready, exp_ready);
            end
            if (up_ready === 1'b0) saw_stall = 1'b1;
            if (dn_valid === 1'b1) begin
                checks++; if (q.size() == 0 || resultado !== q[0]) begin
                    errors++; $display("FAIL stream%0d_data c%0d got %h want %h", mode, cyc, resultado, (q.size() == 0) ? 8'hxx : q[0]);
                end
            end
            acc = up_valid && (up_ready === 1'b1);
            drn = (dn_valid === 1'b1) && dn_ready;
            if (drn && q.size() > 0) begin
                void'(q.pop_front());
                drained++;
            end
            if (acc) begin
                q.push_back(tr[idx]);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        up_valid = 1'b0;
        dn_ready = 1'b1;
        checks++; if (drained != 5) begin
            errors++; $display("FAIL stream%0d_count got %0d want 5", mode, drained);
        end
        if (mode == 0) begin
            checks++; if (cyc != 7) begin
                errors++; $display("FAIL stream0_cycles got %0d want 7", cyc);
            end
        end else begin
            checks++; if (saw_stall !== 1'b1) begin
                errors++; $display("FAIL stream1_stall got %b want 1", saw_stall);
            end
        end
        @(posedge clk); #1;
        checks++; if (dn_valid !== 1'b0) begin
            errors++; $display("FAIL stream%0d_extra got %b want 0", mode, dn_valid);
        end
    endtask

    // Fill both stages under backpressure, reset, then restart
    task automatic test_reset_midop();
        dn_ready = 1'b0;
        producto = 8'd144; exponente = 6'd7; signo = 1'b0; cero = 1'b0;
        up_valid = 1'b1;
        @(posedge clk); #1;
        producto = 8'd64;
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL mid_ready1 got %b want 1", up_ready); end
        @(posedge clk); #1;
        checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b want 0", up_ready); end
        checks++; if (dn_valid !== 1'b1 || resultado !== 8'h41) begin
            errors++; $display("FAIL mid_held got v=%b %h want v=1 41", dn_valid, resultado);
        end
        producto = 8'd108;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", dn_valid); end
        checks++; if (resultado !== 8'h00) begin errors++; $display("FAIL mid_rst_res got %h want 00", resultado); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", up_ready); end
        dn_ready = 1'b1;
        producto = 8'd100; exponente = 6'd7;
        up_valid = 1'b1;
        @(posedge clk); #1;
        up_valid = 1'b0;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL mid_post_early got %b want 0", dn_valid); end
        @(posedge clk); #1;
        checks++; if (dn_valid !== 1'b1 || resultado !== 8'h3C) begin
            errors++; $display("FAIL mid_post got v=%b %h want v=1 3C", dn_valid, resultado);
        end
        @(posedge clk); #1;
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL mid_post_drain got %b want 0", dn_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_stream(0);
        test_stream(1);
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
